alu_seq_ctrl: RTL and testbench

- Command-side initiator for the 4-bit ALU. Accepts opcode/operand commands over a valid/ready handshake and drives registered inputs into the ALU.
- Waits one settle cycle, then captures the ALU result and flags. Returns them over a valid/ready response channel.
- Also supports chained operations (previous result used as operand A) and counts completed operations.

---
 rtl/alu_seq_pkg.sv | 26 ++
 rtl/alu_seq_golden.sv | 46 ++++
 rtl/alu_seq_ctrl.sv | 135 +++++++++++++
 tb/tb_alu_seq_ctrl.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU command sequencer.
//   - opcode encodings understood by the 4-bit ALU (OP_ADD..OP_EQ)
//   - sequencer FSM state encoding (S_IDLE/S_EXEC/S_RESP)
//   - bit positions inside the {carry, overflow, zero} flag vector
package alu_seq_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_NOT = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_LT  = 3'b110;
  localparam logic [2:0] OP_EQ  = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam int FLG_ZERO  = 0;
  localparam int FLG_OVF   = 1;
  localparam int FLG_CARRY = 2;

endpackage

// File: rtl/alu_seq_golden.sv
// Combinational reference model of the ALU, used to cross-check the real
// ALU's result and flags.
//   op    : function select (alu_seq_pkg opcodes)
//   a, b  : operands
//   res   : expected result
//   flags : expected {carry, overflow, zero}; only add/sub produce flags
module alu_seq_golden
  import alu_seq_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [2:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] res,
  output logic [2:0]   flags
);

  logic [W-1:0] b_eff;
  logic [W:0]   sum;

  always_comb begin
    // Subtraction is done as A + two's complement of B, so carry is the
    // "no borrow" carry out of that addition.
    b_eff = (op == OP_SUB) ? (~b + W'(1)) : b;
    sum   = {1'b0, a} + {1'b0, b_eff};
    res   = '0;
    flags = '0;
    case (op)
      OP_ADD, OP_SUB: begin
        res              = sum[W-1:0];
        flags[FLG_CARRY] = sum[W];
        flags[FLG_OVF]   = (a[W-1] == b_eff[W-1]) && (sum[W-1] != a[W-1]);
        flags[FLG_ZERO]  = (sum[W-1:0] == '0);
      end
      OP_NOT:  res = ~a;
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_LT:   res = {{(W-1){1'b0}}, (a < b)};
      OP_EQ:   res = {{(W-1){1'b0}}, (a == b)};
      default: res = '0;
    endcase
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Command-side initiator for the 4-bit ALU.
// Accepts a command, registers it onto the ALU inputs, waits one settle
// cycle, captures result and flags, and returns them as a response.
// Optional self-check: define ALU_SEQ_CHECK_EN to build a golden model that
// flags any ALU disagreement on chk_err (sticky until rst); otherwise
// chk_err is tied low and no checker logic exists.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready;
// a producer holds valid and its payload stable until that edge.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   cmd_valid/cmd_ready      command handshake
//   cmd_op/cmd_a/cmd_b       opcode and operands
//   cmd_chain                use last captured result as operand A
//   alu_fnselec/alu_a/alu_b  registered drive into the ALU
//   alu_res/alu_zero/alu_overflow/alu_carry  ALU outputs
//   rsp_valid/rsp_ready      response handshake
//   rsp_res/rsp_flags        captured result and {carry, overflow, zero}
//   op_count                 completed responses, wraps
//   chk_err                  sticky golden-model disagreement
//   dbg_state                current FSM state
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int W     = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [W-1:0]     cmd_a,
  input  logic [W-1:0]     cmd_b,
  input  logic             cmd_chain,
  output logic [2:0]       alu_fnselec,
  output logic [W-1:0]     alu_a,
  output logic [W-1:0]     alu_b,
  input  logic [W-1:0]     alu_res,
  input  logic             alu_zero,
  input  logic             alu_overflow,
  input  logic             alu_carry,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [W-1:0]     rsp_res,
  output logic [2:0]       rsp_flags,
  output logic [CNT_W-1:0] op_count,
  output logic             chk_err,
  output logic [1:0]       dbg_state
);

  state_t       state, state_nxt;
  logic [W-1:0] last_res;
  logic         cmd_fire;
  logic         rsp_fire;

  // Ready is gated by rst so it reads 0 for the whole reset window.
  assign cmd_ready = (state == S_IDLE) && !rst;
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign rsp_fire  = (state == S_RESP) && rsp_valid && rsp_ready;
  assign dbg_state = state;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (cmd_fire) state_nxt = S_EXEC;
      S_EXEC:  state_nxt = S_RESP;
      S_RESP:  if (rsp_fire) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      alu_fnselec <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      rsp_valid   <= 1'b0;
      rsp_res     <= '0;
      rsp_flags   <= '0;
      op_count    <= '0;
      last_res    <= '0;
    end else begin
      state <= state_nxt;
      // ALU inputs move only on acceptance and otherwise hold.
      if (cmd_fire) begin
        alu_fnselec <= cmd_op;
        alu_a       <= cmd_chain ? last_res : cmd_a;
        alu_b       <= cmd_b;
      end
      // EXEC is the single settle cycle; capture at its closing edge.
      if (state == S_EXEC) begin
        rsp_res   <= alu_res;
        last_res  <= alu_res;
        rsp_flags <= {alu_carry, alu_overflow, alu_zero};
        rsp_valid <= 1'b1;
      end
      if (rsp_fire) begin
        rsp_valid <= 1'b0;
        op_count  <= op_count + CNT_W'(1);
      end
    end
  end

`ifdef ALU_SEQ_CHECK_EN
  logic [W-1:0] gold_res;
  logic [2:0]   gold_flags;
  logic         chk_err_q;

  alu_seq_golden #(.W(W)) u_golden (
    .op    (alu_fnselec),
    .a     (alu_a),
    .b     (alu_b),
    .res   (gold_res),
    .flags (gold_flags)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      chk_err_q <= 1'b0;
    end else if ((state == S_EXEC) &&
                 ((alu_res != gold_res) ||
                  ({alu_carry, alu_overflow, alu_zero} != gold_flags))) begin
      chk_err_q <= 1'b1;
    end
  end

  assign chk_err = chk_err_q;
`else
  assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: a bench-side ALU drives the DUT's alu_* inputs,
// a transaction-level model predicts every output each cycle, and directed
// commands carry hand-computed literal expectations.
module tb_alu_seq_ctrl;
  import alu_seq_pkg::*;

`ifdef ALU_SEQ_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready, cmd_chain;
  logic [2:0] cmd_op;
  logic [3:0] cmd_a, cmd_b;
  logic [2:0] alu_fnselec;
  logic [3:0] alu_a, alu_b, alu_res, alu_res_raw;
  logic       alu_zero, alu_overflow, alu_carry;
  logic       rsp_valid, rsp_ready;
  logic [3:0] rsp_res;
  logic [2:0] rsp_flags;
  logic [7:0] op_count;
  logic       chk_err;
  logic [1:0] dbg_state;
  logic       corrupt;

  int n_vec  = 0;
  int n_miss = 0;
  bit chk_on = 1'b0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- ALU reference arithmetic ----------------
  // Returns {carry, overflow, zero, res[3:0]} using plain integer math.
  function automatic logic [6:0] alu_fn(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    int ua, ub, bp, sum, sa, sb, ss;
    logic [3:0] r;
    logic c, o, z;
    ua = int'(a); ub = int'(b);
    c = 1'b0; o = 1'b0; z = 1'b0; r = 4'd0;
    case (op)
      3'b000, 3'b001: begin
        bp  = (op == 3'b001) ? ((16 - ub) % 16) : ub;
        sum = ua + bp;
        r   = 4'(sum % 16);
        c   = (sum >= 16);
        sa  = (ua >= 8) ? ua - 16 : ua;
        sb  = (bp >= 8) ? bp - 16 : bp;
        ss  = sa + sb;
        o   = (ss > 7) || (ss < -8);
        z   = (r == 4'd0);
      end
      3'b010: r = ~a;
      3'b011: r = a & b;
      3'b100: r = a | b;
      3'b101: r = a ^ b;
      3'b110: r = (ua < ub) ? 4'd1 : 4'd0;
      default: r = (ua == ub) ? 4'd1 : 4'd0;
    endcase
    return {c, o, z, r};
  endfunction

  // Bench-side ALU; corrupt flips result bit 0 to emulate a faulty ALU.
  assign {alu_carry, alu_overflow, alu_zero, alu_res_raw} = alu_fn(alu_fnselec, alu_a, alu_b);
  assign alu_res = alu_res_raw ^ {3'b000, corrupt};

  alu_seq_ctrl #(.W(4), .CNT_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_a        (cmd_a),
    .cmd_b        (cmd_b),
    .cmd_chain    (cmd_chain),
    .alu_fnselec  (alu_fnselec),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_res      (alu_res),
    .alu_zero     (alu_zero),
    .alu_overflow (alu_overflow),
    .alu_carry    (alu_carry),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_res      (rsp_res),
    .rsp_flags    (rsp_flags),
    .op_count     (op_count),
    .chk_err      (chk_err),
    .dbg_state    (dbg_state)
  );

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: phase 0 = waiting for a command, 1 = command
  // issued and ALU settling, 2 = response offered.
  int         m_phase = 0;
  logic [2:0] m_op    = 3'd0;
  logic [3:0] m_a     = 4'd0;
  logic [3:0] m_b     = 4'd0;
  logic [3:0] m_res   = 4'd0;
  logic [2:0] m_flags = 3'd0;
  logic [3:0] m_last  = 4'd0;
  logic [7:0] m_count = 8'd0;
  logic       m_chk   = 1'b0;
  logic [6:0] m_alu;

  always @(negedge clk) begin
    if (chk_on) begin
      check("cmd_ready",   cmd_ready,   (m_phase == 0) && !rst);
      check("rsp_valid",   rsp_valid,   m_phase == 2);
      check("rsp_res",     rsp_res,     m_res);
      check("rsp_flags",   rsp_flags,   m_flags);
      check("op_count",    op_count,    m_count);
      check("alu_fnselec", alu_fnselec, m_op);
      check("alu_a",       alu_a,       m_a);
      check("alu_b",       alu_b,       m_b);
      check("chk_err",     chk_err,     m_chk);
    end
    // Predict the effect of the upcoming rising edge.
    if (rst) begin
      m_phase = 0; m_op = 3'd0; m_a = 4'd0; m_b = 4'd0; m_res = 4'd0;
      m_flags = 3'd0; m_last = 4'd0; m_count = 8'd0; m_chk = 1'b0;
    end else if (m_phase == 0) begin
      if (cmd_valid) begin
        m_op = cmd_op; m_a = cmd_chain ? m_last : cmd_a; m_b = cmd_b;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      m_alu   = alu_fn(m_op, m_a, m_b);
      m_res   = m_alu[3:0] ^ {3'b000, corrupt};
      m_flags = m_alu[6:4];
      m_last  = m_res;
      if (corrupt && CHK_EN) m_chk = 1'b1;
      m_phase = 2;
    end else begin
      if (rsp_ready) begin
        m_count = m_count + 8'd1;
        m_phase = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Present a command and return right after the edge that accepts it.
  task automatic send_cmd(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b, input logic chain);
    int k;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_chain = chain;
    k = 0;
    @(negedge clk);
    while (!cmd_ready && k < 20) begin @(negedge clk); k++; end
    check("cmd_accept_wait", cmd_ready, 1'b1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!rsp_valid && lat < 20);
  endtask

  // Full command with literal expectations; rsp_ready is assumed high.
  task automatic run_cmd(input string name, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                         input logic chain, input logic [3:0] e_res, input logic [2:0] e_flg, input logic [3:0] e_alu_a);
    int lat;
    send_cmd(op, a, b, chain);
    wait_rsp(lat);
    check({name, "_latency"}, lat, 2);
    check({name, "_res"},     rsp_res,   e_res);
    check({name, "_flags"},   rsp_flags, e_flg);
    check({name, "_alu_a"},   alu_a,     e_alu_a);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #300000;
    n_miss++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // ---------------- directed sequence ----------------
  initial begin
    int lat;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_a = 4'd0; cmd_b = 4'd0;
    cmd_chain = 1'b0; rsp_ready = 1'b1; corrupt = 1'b0;
    @(posedge clk);
    chk_on = 1'b1;
    @(negedge clk);
    check("reset_cmd_ready", cmd_ready, 1'b0);
    check("reset_rsp_valid", rsp_valid, 1'b0);
    check("reset_op_count",  op_count,  8'd0);
    check("reset_alu_a",     alu_a,     4'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 7 + 9 = 16: result wraps to 0 with carry; signed 7 + (-7) cannot overflow.
    run_cmd("add_7_9", OP_ADD, 4'd7, 4'd9, 1'b0, 4'd0, 3'b101, 4'd7);
    @(posedge clk); #1;
    check("add_7_9_count", op_count, 8'd1);

    run_cmd("sub_5_3", OP_SUB, 4'd5, 4'd3, 1'b0, 4'd2,  3'b100, 4'd5);
    run_cmd("sub_3_5", OP_SUB, 4'd3, 4'd5, 1'b0, 4'd14, 3'b000, 4'd3);
    run_cmd("lt_2_9",  OP_LT,  4'd2, 4'd9, 1'b0, 4'd1,  3'b000, 4'd2);
    run_cmd("eq_4_4",  OP_EQ,  4'd4, 4'd4, 1'b0, 4'd1,  3'b000, 4'd4);
    run_cmd("and_0_0", OP_AND, 4'd0, 4'd0, 1'b0, 4'd0,  3'b000, 4'd0);
    run_cmd("not_6",   OP_NOT, 4'd6, 4'd0, 1'b0, 4'd9,  3'b000, 4'd6);
    run_cmd("add_3_4", OP_ADD, 4'd3, 4'd4, 1'b0, 4'd7,  3'b000, 4'd3);
    run_cmd("chain_xor", OP_XOR, 4'hF, 4'd2, 1'b1, 4'd5, 3'b000, 4'd7);

    // Backpressure: response held for 5 cycles while a new command waits.
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    send_cmd(OP_OR, 4'hA, 4'h5, 1'b0);
    wait_rsp(lat);
    check("bp_latency", lat, 2);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_op = OP_XOR; cmd_a = 4'd1; cmd_b = 4'd1; cmd_chain = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_rsp_valid", rsp_valid, 1'b1);
      check("bp_rsp_res",   rsp_res,   4'hF);
      check("bp_cmd_ready", cmd_ready, 1'b0);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_count", op_count, 8'd10);
    @(negedge clk);
    check("bp_not_consumed", alu_fnselec, OP_OR);

    // Reset while the command is in its settle cycle.
    send_cmd(OP_ADD, 4'd1, 4'd1, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_exec_rsp_valid", rsp_valid,   1'b0);
    check("rst_exec_count",     op_count,    8'd0);
    check("rst_exec_alu_a",     alu_a,       4'd0);
    check("rst_exec_fnselec",   alu_fnselec, 3'd0);
    check("rst_exec_cmd_ready", cmd_ready,   1'b0);
    check("rst_exec_rsp_res",   rsp_res,     4'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("rst_no_rsp", rsp_valid, 1'b0);
    end

    // Chain right after reset uses A = 0.
    run_cmd("chain_first", OP_ADD, 4'd9, 4'd3, 1'b1, 4'd3, 3'b000, 4'd0);

    // Faulty ALU result: chk_err sets only when the checker is built.
    corrupt = 1'b1;
    run_cmd("bad_alu", OP_ADD, 4'd2, 4'd2, 1'b0, 4'd5, 3'b000, 4'd2);
    corrupt = 1'b0;
    check("chk_err_set", chk_err, CHK_EN);
    // 0 - 8: B' = 8, sum 8, no carry; sign rule on A and B' reports no overflow.
    run_cmd("sub_0_8", OP_SUB, 4'd0, 4'd8, 1'b0, 4'd8, 3'b000, 4'd0);
    check("chk_err_sticky", chk_err, CHK_EN);

    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("chk_err_cleared", chk_err, 1'b0);

    // Counter wrap: 256 completed responses return op_count to 0.
    for (int i = 0; i < 256; i++) begin
      send_cmd(3'(i % 8), 4'(i % 16), 4'((i * 7) % 16), (i % 5) == 0);
      wait_rsp(lat);
      check("wrap_latency", lat, 2);
      if (i == 254) begin
        @(posedge clk); #1;
        check("count_255", op_count, 8'd255);
      end
    end
    @(posedge clk); #1;
    check("count_wrap", op_count, 8'd0);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
